// File: rtl/cordic_pkg.sv
// Shared constants and types for the iterative CORDIC polar-to-rectangular engine.
// Angles are binary angle units: 2^32 is one full turn.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    ITERATE,
    DONE
  } state_t;

  localparam logic [31:0] ANG_PI          = 32'h8000_0000;
  localparam logic [31:0] ANG_HALF_PI     = 32'h4000_0000;
  localparam logic [31:0] CORDIC_INV_GAIN = 32'h26DD_3B6A;

  // round(atan(2^-i) * 2^32 / (2*pi))
  localparam logic [31:0] ATAN_TBL [32] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
  };

endpackage

// File: rtl/cordic_rot_step.sv
// One rotation-mode CORDIC micro-rotation; direction follows the sign of z.
// Purely combinational; the caller registers the results.
module cordic_rot_step
  import cordic_pkg::*;
#(
  parameter int WID = 32
) (
  input  logic [WID-1:0] x,
  input  logic [WID-1:0] y,
  input  logic [WID-1:0] z,
  input  logic [4:0]     step,
  output logic [WID-1:0] x_next,
  output logic [WID-1:0] y_next,
  output logic [WID-1:0] z_next
);

  logic [WID-1:0] x_shr;
  logic [WID-1:0] y_shr;
  logic [WID-1:0] atan;

  assign x_shr = $signed(x) >>> step;
  assign y_shr = $signed(y) >>> step;
  assign atan  = WID'(ATAN_TBL[step]);

  always_comb begin
    if (!z[WID-1]) begin
      x_next = x - y_shr;
      y_next = y + x_shr;
      z_next = z - atan;
    end else begin
      x_next = x + y_shr;
      y_next = y - x_shr;
      z_next = z + atan;
    end
  end

endmodule

// File: rtl/cordic_polar2rect.sv
// Iterative CORDIC polar-to-rectangular converter: one micro-rotation per clock,
// quadrant fold and 1/K gain applied before iterating, valid/ready on both sides.
module cordic_polar2rect
  import cordic_pkg::*;
#(
  parameter int ITER = 30,
  parameter int WID  = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WID-1:0] in_angle,
  input  logic [WID-1:0] in_mag,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WID-1:0] out_x,
  output logic [WID-1:0] out_y,
  output logic [WID-1:0] out_resid,
  output logic           busy
);

  localparam logic [4:0] LAST_STEP = 5'(ITER - 1);

  state_t         state;
  logic [WID-1:0] x;
  logic [WID-1:0] y;
  logic [WID-1:0] z;
  logic [4:0]     step;

  logic                   swap;
  logic [WID-1:0]         m;
  logic signed [2*WID-1:0] m_ext;
  logic signed [2*WID-1:0] g_ext;
  logic [WID-1:0]         gain_x;
  logic [WID-1:0]         x_next;
  logic [WID-1:0]         y_next;
  logic [WID-1:0]         z_next;

  // In PREP, x still holds the latched magnitude and z the raw angle.
  // Angles in the left half-plane are turned by 180 deg and the magnitude negated.
  assign swap   = z[WID-1] ^ z[WID-2];
  assign m      = swap ? -x : x;
  assign m_ext  = {{WID{m[WID-1]}}, m};
  assign g_ext  = {{WID{1'b0}}, WID'(CORDIC_INV_GAIN)};
  assign gain_x = WID'((m_ext * g_ext) >>> 30);

  cordic_rot_step #(
    .WID (WID)
  ) u_step (
    .x      (x),
    .y      (y),
    .z      (z),
    .step   (step),
    .x_next (x_next),
    .y_next (y_next),
    .z_next (z_next)
  );

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      step      <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_resid <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            z     <= in_angle;
            x     <= in_mag;
            y     <= '0;
            state <= PREP;
          end
        end
        PREP: begin
          z     <= swap ? z + WID'(ANG_PI) : z;
          x     <= gain_x;
          y     <= '0;
          step  <= '0;
          state <= ITERATE;
        end
        ITERATE: begin
          x    <= x_next;
          y    <= y_next;
          z    <= z_next;
          step <= step + 5'd1;
          if (step == LAST_STEP) begin
            out_x     <= x_next;
            out_y     <= y_next;
            out_resid <= z_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_polar2rect.sv
// Bench for cordic_polar2rect: directed vector table, random polar inputs against
// a real-arithmetic model, backpressure and mid-operation reset sequences.
module tb_cordic_polar2rect;

  localparam int ITER      = 30;
  localparam int TOL       = 64;
  localparam int RESID_TOL = 5;   // 4 LSB plus atan(2^-29) rounded = 1
  localparam int LAT_EDGES = ITER + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_angle;
  logic [31:0] in_mag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_x;
  logic [31:0] out_y;
  logic [31:0] out_resid;
  logic        busy;

  int tests = 0;
  int fails = 0;

  cordic_polar2rect #(
    .ITER (ITER),
    .WID  (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_angle  (in_angle),
    .in_mag    (in_mag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_resid (out_resid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] angle;
    logic [31:0] mag;
    logic [31:0] ex;
    logic [31:0] ey;
    int          tol;
  } vec_t;

  vec_t vecs [7];

  task automatic chk_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_tol(input string name, input logic [31:0] act, input logic [31:0] exp,
                         input int tol);
    longint d;
    d = longint'($signed(act)) - longint'($signed(exp));
    tests++;
    if (d > tol || d < -tol) begin
      fails++;
      $display("FAIL %s: got %h want %h (+-%0d)", name, act, exp, tol);
    end
  endtask

  task automatic chk_real(input string name, input logic [31:0] act, input real exp,
                          input real tol);
    real d;
    d = $itor($signed(act)) - exp;
    tests++;
    if (d > tol || d < -tol) begin
      fails++;
      $display("FAIL %s: got %h want %.1f (+-%.0f)", name, act, exp, tol);
    end
  endtask

  // Submit one request, measure edges to out_valid, then accept the result.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] m,
                         output logic [31:0] rx, output logic [31:0] ry,
                         output logic [31:0] rr, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    chk_bit("in_ready_before_req", in_ready, 1'b1);
    in_angle = a;
    in_mag   = m;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    rx = out_x;
    ry = out_y;
    rr = out_resid;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk_bit("out_valid_drop", out_valid, 1'b0);
    chk_bit("in_ready_return", in_ready, 1'b1);
    $display("[TB] txn angle=%h mag=%h -> x=%h y=%h resid=%h lat=%0d", a, m, rx, ry, rr, lat);
  endtask

  logic [31:0] rx, ry, rr, cx, cy;
  int          lat;

  initial begin
    vecs[0] = '{32'h0000_0000, 32'h2000_0000, 32'h2000_0000, 32'h0000_0000, TOL};
    vecs[1] = '{32'h4000_0000, 32'h2000_0000, 32'h0000_0000, 32'h2000_0000, TOL};
    vecs[2] = '{32'h8000_0000, 32'h4000_0000, 32'hC000_0000, 32'h0000_0000, TOL};
    vecs[3] = '{32'h2000_0000, 32'h4000_0000, 32'h2D41_3CCD, 32'h2D41_3CCD, TOL};
    vecs[4] = '{32'hC000_0000, 32'h2000_0000, 32'h0000_0000, 32'hE000_0000, TOL};
    vecs[5] = '{32'hE000_0000, 32'hC000_0000, 32'hD2BE_C333, 32'h2D41_3CCD, TOL};
    vecs[6] = '{32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_angle  = '0;
    in_mag    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_bit("rst_in_ready", in_ready, 1'b1);
    chk_bit("rst_out_valid", out_valid, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_tol("rst_out_x", out_x, 32'h0, 0);
    chk_tol("rst_out_y", out_y, 32'h0, 0);
    chk_tol("rst_out_resid", out_resid, 32'h0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].angle, vecs[i].mag, rx, ry, rr, lat);
      chk_int("vec_latency", lat, LAT_EDGES);
      chk_tol("vec_x", rx, vecs[i].ex, vecs[i].tol);
      chk_tol("vec_y", ry, vecs[i].ey, vecs[i].tol);
      chk_tol("vec_resid", rr, 32'h0, RESID_TOL);
    end

    // Random polar inputs against real-valued mag*cos / mag*sin
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a;
      int          m;
      real         ang;
      a = $urandom;
      m = int'($urandom_range(32'h4000_0000, 0));
      if ($urandom_range(1, 0) == 1) m = -m;
      ang = 6.283185307179586 * $itor($signed(a)) / 4294967296.0;
      run_txn(a, m, rx, ry, rr, lat);
      chk_int("rand_latency", lat, LAT_EDGES);
      chk_real("rand_x", rx, $itor(m) * $cos(ang), 64.0);
      chk_real("rand_y", ry, $itor(m) * $sin(ang), 64.0);
      chk_tol("rand_resid", rr, 32'h0, RESID_TOL);
    end

    // Backpressure: result held, new requests refused while DONE
    in_angle = 32'h2000_0000;
    in_mag   = 32'h4000_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    chk_int("bp_latency", lat, LAT_EDGES);
    cx = out_x;
    cy = out_y;
    chk_tol("bp_x", cx, 32'h2D41_3CCD, TOL);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        in_valid = 1'b1;
        in_angle = 32'h4000_0000;
        in_mag   = 32'h1000_0000;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk_bit("bp_out_valid_held", out_valid, 1'b1);
      chk_tol("bp_x_stable", out_x, cx, 0);
      chk_tol("bp_y_stable", out_y, cy, 0);
      chk_bit("bp_in_ready_low", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk_bit("bp_release_valid", out_valid, 1'b0);
    chk_bit("bp_release_ready", in_ready, 1'b1);
    chk_tol("bp_x_kept", out_x, cx, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk_bit("bp_pulse_ignored", busy, 1'b0);
    end
    $display("[TB] txn backpressure x=%h y=%h", cx, cy);

    // Reset in the middle of ITERATE at step 10
    in_angle = 32'h1000_0000;
    in_mag   = 32'h3000_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    chk_bit("mid_busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk_bit("mid_rst_in_ready", in_ready, 1'b1);
    chk_bit("mid_rst_out_valid", out_valid, 1'b0);
    chk_bit("mid_rst_busy", busy, 1'b0);
    chk_tol("mid_rst_out_x", out_x, 32'h0, 0);
    chk_tol("mid_rst_out_y", out_y, 32'h0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (out_valid) seen = 1'b1;
      end
      chk_bit("mid_rst_no_result", seen, 1'b0);
    end
    $display("[TB] txn reset at step 10 aborted");
    run_txn(32'hC000_0000, 32'h2000_0000, rx, ry, rr, lat);
    chk_int("post_rst_latency", lat, LAT_EDGES);
    chk_tol("post_rst_x", rx, 32'h0000_0000, TOL);
    chk_tol("post_rst_y", ry, 32'hE000_0000, TOL);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
